// File: rtl/led_trail_pwm.sv
// ---------------------------------------------------------------------------
// led_trail_pwm
//
// Purpose:
//   This is the LED output stage for the knight-rider scanner. Each of the six
//   LEDs has a 4-bit brightness level. When the scanner head is on an LED, that
//   LED is set to full brightness. After that it fades one step on every decay
//   tick, which leaves a fading trail behind the head. Each brightness is shown
//   on the board as active-low PWM.
//
// Parameters:
//   PWM_PRESCALE : clk cycles per PWM step (>= 1)
//   DECAY_TICKS  : clk cycles per brightness decrement (>= 2)
//
// Ports:
//   clk   : system clock
//   rst_n : synchronous, active-low reset
//   head  : one bit per LED, high = LED is the current scanner position
//   led   : registered active-low LED drive (0 = lit)
//
// Configuration macro:
//   LED_GAMMA_EN : when defined, the level passes through a 16-entry gamma
//                  table before the PWM compare. When it is undefined, the
//                  level is used linearly.
// ---------------------------------------------------------------------------
module led_trail_pwm #(
    parameter int PWM_PRESCALE = 16,
    parameter int DECAY_TICKS  = 425_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] head,
    output logic [5:0] led
);

    localparam int PRE_W = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
    localparam int DEC_W = $clog2(DECAY_TICKS);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PWM_PRESCALE - 1);
    localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECAY_TICKS - 1);

    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [3:0]       pwm_cnt_q, pwm_cnt_d;
    logic [DEC_W-1:0] dec_cnt_q, dec_cnt_d;
    logic [3:0]       level_q [6];
    logic [3:0]       level_d [6];
    logic [5:0]       led_q, led_d;
    logic             pre_wrap;
    logic             decay_tick;

    // This maps a level to the brightness that the PWM compare uses.
    // The gamma table makes each fade step look roughly even to the eye.
    function automatic logic [3:0] eff_of(input logic [3:0] lvl);
`ifdef LED_GAMMA_EN
        case (lvl)
            4'd4, 4'd5, 4'd6: eff_of = 4'd1;
            4'd7, 4'd8:       eff_of = 4'd2;
            4'd9:             eff_of = 4'd3;
            4'd10:            eff_of = 4'd4;
            4'd11:            eff_of = 4'd5;
            4'd12:            eff_of = 4'd7;
            4'd13:            eff_of = 4'd9;
            4'd14:            eff_of = 4'd12;
            4'd15:            eff_of = 4'd15;
            default:          eff_of = 4'd0;
        endcase
`else
        eff_of = lvl;
`endif
    endfunction

    // The prescaler sets the PWM step rate. pwm_cnt advances only when the
    // prescaler wraps, and it rolls over naturally from 15 to 0.
    always_comb begin
        pre_wrap  = (pre_cnt_q == PRE_LAST);
        pre_cnt_d = pre_wrap ? '0 : pre_cnt_q + 1'b1;
        pwm_cnt_d = pre_wrap ? pwm_cnt_q + 4'd1 : pwm_cnt_q;
    end

    // The decay timer runs freely and does not depend on the head input.
    // decay_tick is high for one cycle in each period, on the last count.
    always_comb begin
        decay_tick = (dec_cnt_q == DEC_LAST);
        dec_cnt_d  = decay_tick ? '0 : dec_cnt_q + 1'b1;
    end

    // Each channel is updated on its own. The head input has priority over
    // decay, so a head that arrives on a tick cycle still sets the level to
    // full. A level that is already 0 stays at 0 instead of wrapping round.
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            level_d[i] = level_q[i];
            if (head[i]) begin
                level_d[i] = 4'd15;
            end else if (decay_tick && (level_q[i] != 4'd0)) begin
                level_d[i] = level_q[i] - 4'd1;
            end
        end
    end

    // The LED is lit while its brightness is above the PWM count. Because of
    // this, brightness 15 still has one dark step in each frame, and
    // brightness 0 is never lit.
    always_comb begin
        led_d = '1;
        for (int i = 0; i < 6; i++) begin
            led_d[i] = ~(eff_of(level_q[i]) > pwm_cnt_q);
        end
    end

    // This block holds all the state. Reset clears the counters and the
    // levels, and it turns every LED off. There is no trail left over after
    // a reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt_q <= '0;
            pwm_cnt_q <= '0;
            dec_cnt_q <= '0;
            led_q     <= '1;
            for (int i = 0; i < 6; i++) begin
                level_q[i] <= '0;
            end
        end else begin
            pre_cnt_q <= pre_cnt_d;
            pwm_cnt_q <= pwm_cnt_d;
            dec_cnt_q <= dec_cnt_d;
            led_q     <= led_d;
            for (int i = 0; i < 6; i++) begin
                level_q[i] <= level_d[i];
            end
        end
    end

    assign led = led_q;

endmodule

// File: tb/tb_led_trail_pwm.sv
// ---------------------------------------------------------------------------
// tb_led_trail_pwm
//
// Purpose:
//   This is the testbench for led_trail_pwm. It uses PWM_PRESCALE=2 and
//   DECAY_TICKS=8. The bench keeps a reference model written in plain
//   arithmetic: it counts the cycles since reset, finds the PWM step and the
//   decay ticks from that count, and keeps the six levels in an integer array.
//   The led output is compared with this model after every clock edge.
//   Compile with LED_GAMMA_EN defined to check the gamma build.
// ---------------------------------------------------------------------------
module tb_led_trail_pwm;

    localparam int PRESCALE = 2;
    localparam int DECAY    = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] head = '0;
    logic [5:0] led;

    int         vectors = 0;
    int         miscompares = 0;

    // Reference model state
    int         lvl [6];
    int         cyc = 0;
    logic [5:0] exp_led = '1;

    led_trail_pwm #(
        .PWM_PRESCALE(PRESCALE),
        .DECAY_TICKS (DECAY)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .head (head),
        .led  (led)
    );

    always #5 clk = ~clk;

    // This gives the perceived brightness for a level in the current build.
    function automatic int model_eff(input int l);
        int gtab [16] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3, 4, 5, 7, 9, 12, 15};
`ifdef LED_GAMMA_EN
        return gtab[l];
`else
        return (gtab[0] == 0) ? l : l;
`endif
    endfunction

    // This steps the model by one clock edge. The count of edges since reset
    // gives the PWM step ((cyc / PRESCALE) % 16) and whether this edge is a
    // decay tick (every DECAY-th edge).
    task automatic model_edge(input logic rn, input logic [5:0] h);
        int pwm;
        bit tick;
        if (!rn) begin
            for (int i = 0; i < 6; i++) lvl[i] = 0;
            cyc     = 0;
            exp_led = '1;
        end else begin
            pwm  = (cyc / PRESCALE) % 16;
            tick = ((cyc % DECAY) == DECAY - 1);
            for (int i = 0; i < 6; i++) begin
                exp_led[i] = !(model_eff(lvl[i]) > pwm);
                if (h[i])                lvl[i] = 15;
                else if (tick && lvl[i] > 0) lvl[i] = lvl[i] - 1;
            end
            cyc++;
        end
    endtask

    task automatic checkOutput(input string tag);
        vectors++;
        assert (led === exp_led) else begin
            miscompares++;
            $error("[TB] FAIL %s: cycle %0d observed led=%b expected led=%b", tag, cyc, led, exp_led);
        end
    endtask

    // This drives one cycle of input on the falling edge. After the next
    // rising edge it updates the model and checks the output.
    task automatic applyStimulus(input logic rn, input logic [5:0] h, input string tag);
        @(negedge clk);
        rst_n = rn;
        head  = h;
        @(posedge clk);
        #1;
        model_edge(rn, h);
        checkOutput(tag);
    endtask

    initial begin
        int  lows;
        bit  found;
        for (int i = 0; i < 6; i++) lvl[i] = 0;

        $display("[TB] reset held with all heads high");
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 6'b111111, "reset");

        $display("[TB] head on LED 0 held for 200 cycles");
        lows = 0;
        for (int k = 0; k < 200; k++) begin
            applyStimulus(1'b1, 6'b000001, "head_hold");
            if (k >= 168 && led[0] == 1'b0) lows++;
        end
        vectors++;
        assert (lows === 30) else begin
            miscompares++;
            $error("[TB] FAIL duty_full: observed %0d lit cycles expected 30", lows);
        end

        $display("[TB] single-cycle head on LED 2, then fade");
        applyStimulus(1'b1, 6'b000100, "decay_set");
        for (int k = 0; k < 160; k++) applyStimulus(1'b1, 6'b000000, "decay");
        lows = 0;
        for (int k = 0; k < 32; k++) begin
            applyStimulus(1'b1, 6'b000000, "faded");
            if (led[2] == 1'b0) lows++;
        end
        vectors++;
        assert (lows === 0) else begin
            miscompares++;
            $error("[TB] FAIL faded_off: observed %0d lit cycles expected 0", lows);
        end

        $display("[TB] head on LED 3 on the tick cycle while level is 9");
        applyStimulus(1'b1, 6'b001000, "hvd_set");
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            if (lvl[3] == 9 && (cyc % DECAY) == DECAY - 1) found = 1'b1;
            else applyStimulus(1'b1, 6'b000000, "hvd_wait");
        end
        vectors++;
        assert (found === 1'b1) else begin
            miscompares++;
            $error("[TB] FAIL hvd_timeout: observed found=%b expected 1", found);
        end
        applyStimulus(1'b1, 6'b001000, "hvd_hit");
        vectors++;
        assert (lvl[3] === 15) else begin
            miscompares++;
            $error("[TB] FAIL hvd_model: observed %0d expected 15", lvl[3]);
        end
        for (int k = 0; k < 40; k++) applyStimulus(1'b1, 6'b000000, "hvd_after");

        $display("[TB] reset in the middle of a trail on LEDs 1-4");
        applyStimulus(1'b1, 6'b011110, "mid_set");
        for (int k = 0; k < 13; k++) applyStimulus(1'b1, 6'b000000, "mid_fade");
        applyStimulus(1'b0, 6'b000000, "mid_reset");
        for (int k = 0; k < 40; k++) applyStimulus(1'b1, 6'b000000, "post_reset");
        applyStimulus(1'b1, 6'b100001, "post_head");
        for (int k = 0; k < 40; k++) applyStimulus(1'b1, 6'b000000, "post_head_fade");

        $display("[TB] randomized heads with occasional reset");
        for (int k = 0; k < 1500; k++) begin
            logic [5:0] h;
            logic       rn;
            h  = 6'($urandom) & 6'($urandom) & 6'($urandom);
            rn = ($urandom_range(0, 199) != 0);
            applyStimulus(rn, h, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
